parity_frame_checker: RTL and testbench

- Parametrised successor to the single-bit serial parity checker: receives framed serial data (DATA_BITS data bits, LSB first, then one parity bit) and checks each frame against a selectable even/odd parity rule.
- Adds what the bit-level checker lacks: framing with a start marker, input stalls, a per-frame result pulse, captured data word, abort detection and a saturating error counter.
- Sits between a serial receiver front-end and the status/register layer.

---
 rtl/parity_frame_checker_if.sv | 43 ++++
 rtl/parity_frame_checker.sv | 119 +++++++++++
 tb/tb_parity_frame_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_if.sv
// Bit-stream and result bundle for the parity frame checker.
// The slave modport is the checker; the master is the front-end/status side.
interface parity_frame_checker_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
);
  logic                 bit_valid;
  logic                 bit_in;
  logic                 sof;
  logic                 clear_count;
  logic                 busy;
  logic                 frame_done;
  logic                 parity_error;
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_abort;
  logic [CNT_W-1:0]     err_count;

  modport master (
    output bit_valid,
    output bit_in,
    output sof,
    output clear_count,
    input  busy,
    input  frame_done,
    input  parity_error,
    input  data_out,
    input  frame_abort,
    input  err_count
  );

  modport slave (
    input  bit_valid,
    input  bit_in,
    input  sof,
    input  clear_count,
    output busy,
    output frame_done,
    output parity_error,
    output data_out,
    output frame_abort,
    output err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Framed serial parity checker: LSB-first data bits, one parity bit,
// per-frame result pulse, abort on re-sync and a saturating error counter.
module parity_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  parity_frame_checker_if.slave bus
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0]    LAST = IW'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic             ODD  = 1'(ODD_PARITY);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 abort_q, abort_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      par_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    par_d   = par_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    abort_d = 1'b0;
    cnt_d   = cnt_q;

    if (bus.bit_valid) begin
      if (bus.sof) begin
        // A sof always restarts; mid-frame it discards the partial frame.
        abort_d    = (state_q != IDLE);
        shift_d    = '0;
        shift_d[0] = bus.bit_in;
        par_d      = bus.bit_in;
        idx_d      = (DATA_BITS == 1) ? '0 : IW'(1);
        state_d    = (DATA_BITS == 1) ? PARITY : DATA;
      end else begin
        unique case (state_q)
          IDLE: ;
          DATA: begin
            shift_d[idx_q] = bus.bit_in;
            par_d          = par_q ^ bus.bit_in;
            if (idx_q == LAST) begin
              idx_d   = '0;
              state_d = PARITY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          PARITY: begin
            perr_d  = ((par_q ^ bus.bit_in) != ODD);
            done_d  = 1'b1;
            data_d  = shift_q;
            idx_d   = '0;
            par_d   = 1'b0;
            state_d = IDLE;
            if (perr_d && (cnt_q != CMAX)) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (bus.clear_count) begin
      cnt_d = '0;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.frame_done   = done_q;
  assign bus.parity_error = perr_q;
  assign bus.data_out     = data_q;
  assign bus.frame_abort  = abort_q;
  assign bus.err_count    = cnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: even, odd and 2-bit-counter checkers driven in lockstep.
// Expected frame results are queued at the parity bit and checked on frame_done.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_BITS(8), .CNT_W(8)) if_e ();
  parity_frame_checker_if #(.DATA_BITS(8), .CNT_W(8)) if_o ();
  parity_frame_checker_if #(.DATA_BITS(8), .CNT_W(2)) if_c ();

  parity_frame_checker #(
    .DATA_BITS(8), .ODD_PARITY(0), .CNT_W(8)
  ) u_even (.clk(clk), .reset(rst_n), .bus(if_e.slave));

  parity_frame_checker #(
    .DATA_BITS(8), .ODD_PARITY(1), .CNT_W(8)
  ) u_odd (.clk(clk), .reset(rst_n), .bus(if_o.slave));

  parity_frame_checker #(
    .DATA_BITS(8), .ODD_PARITY(0), .CNT_W(2)
  ) u_cnt (.clk(clk), .reset(rst_n), .bus(if_c.slave));

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       clr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int aborts = 0;
  int cnt_e = 0;
  int cnt_o = 0;
  int cnt_c = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic perr(input logic [7:0] d, input logic p,
                                input logic odd);
    return ((^d) ^ p) != odd;
  endfunction

  task automatic drive(input logic v, input logic b, input logic s,
                       input logic c);
    if_e.bit_valid = v; if_e.bit_in = b;
    if_e.sof = s;       if_e.clear_count = c;
    if_o.bit_valid = v; if_o.bit_in = b;
    if_o.sof = s;       if_o.clear_count = c;
    if_c.bit_valid = v; if_c.bit_in = b;
    if_c.sof = s;       if_c.clear_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic clr, input logic exp_abort,
                            input int stall4, input int stallp);
    drive(1'b1, d[0], 1'b1, 1'b0);
    chk("abort_e", if_e.frame_abort, exp_abort);
    chk("busy_e", if_e.busy, 1);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, d[i], 1'b0, 1'b0);
      if (i == 1) chk("abort_1cyc", if_e.frame_abort, 0);
      if (i == 4) begin
        repeat (stall4) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0);
          chk("busy_stall4", if_e.busy, 1);
        end
      end
    end
    repeat (stallp) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("busy_stallp", if_e.busy, 1);
    end
    sb.push_back('{d, p, clr});
    drive(1'b1, p, 1'b0, clr);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic pe, po;
    if (if_e.frame_abort) aborts++;
    if (if_e.frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", if_e.frame_done, 0);
      end else begin
        e  = sb.pop_front();
        pe = perr(e.data, e.pbit, 1'b0);
        po = perr(e.data, e.pbit, 1'b1);
        cnt_e = e.clr ? 0 : ((pe && cnt_e < 255) ? cnt_e + 1 : cnt_e);
        cnt_o = e.clr ? 0 : ((po && cnt_o < 255) ? cnt_o + 1 : cnt_o);
        cnt_c = e.clr ? 0 : ((pe && cnt_c < 3) ? cnt_c + 1 : cnt_c);
        chk("done_o", if_o.frame_done, 1);
        chk("done_c", if_c.frame_done, 1);
        chk("data_e", if_e.data_out, e.data);
        chk("data_o", if_o.data_out, e.data);
        chk("perr_e", if_e.parity_error, pe);
        chk("perr_o", if_o.parity_error, po);
        chk("perr_c", if_c.parity_error, pe);
        chk("cnt_e", if_e.err_count, cnt_e);
        chk("cnt_o", if_o.err_count, cnt_o);
        chk("cnt_c", if_c.err_count, cnt_c);
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    cnt_e = 0;
    cnt_o = 0;
    cnt_c = 0;
    chk("rst_busy", if_e.busy, 0);
    chk("rst_done", if_e.frame_done, 0);
    chk("rst_perr", if_e.parity_error, 0);
    chk("rst_abort", if_e.frame_abort, 0);
    chk("rst_data", if_e.data_out, 0);
    chk("rst_cnt_e", if_e.err_count, 0);
    chk("rst_cnt_c", if_c.err_count, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(1);
    do_reset(3);
    idle(2);

    // back-to-back frames: good even parity, then bad even parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(3);
    chk("idle_busy", if_e.busy, 0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3, 3);
    idle(3);

    // partial frame of 5 bits, then a re-sync into a full frame
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 0, 0);
    idle(3);
    chk("abort_count", aborts, 1);

    do_reset(2);
    repeat (5) send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    chk("cnt_c_sat", if_c.err_count, 3);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0);
    idle(3);
    chk("cnt_c_clr", if_c.err_count, 0);

    // reset in the middle of a frame, with bit_valid still high
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cnt_e = 0;
    cnt_o = 0;
    cnt_c = 0;
    chk("midrst_busy", if_e.busy, 0);
    chk("midrst_abort", if_e.frame_abort, 0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(4);

    chk("sb_empty", sb.size(), 0);
    chk("abort_total", aborts, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
